// File: rtl/ats21_pkg.sv
// ats21_pkg
//   Shared types for the ATS21 command issuer: command opcodes, the issuer
//   FSM state encoding, and the same-target conflict test applied to the two
//   FIFO heads before they are paired into one core transaction.
package ats21_pkg;

    typedef enum logic [2:0] {
        OP_NOP     = 3'b000,
        OP_SET_CLK = 3'b001,
        OP_EN_CLK  = 3'b010,
        OP_MODE    = 3'b011,
        OP_SET_ALM = 3'b100,
        OP_SET_TMR = 3'b101,
        OP_EN_ALM  = 3'b110
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_RDY,
        ST_ISSUE_HI,
        ST_ISSUE_LO,
        ST_WAIT_STAT,
        ST_RESP
    } issuer_state_e;

    // Two commands collide when they address the same core resource:
    // clock ops share a 4-bit target, timer/alarm ops (incl. 3'b111) a 5-bit
    // target, and MODE is a single global resource.
    function automatic logic targets_conflict(input logic [31:0] a, input logic [31:0] b);
        logic [2:0] op_a, op_b;
        logic       clk_a, clk_b, tmr_a, tmr_b, mode_both;
        op_a      = a[31:29];
        op_b      = b[31:29];
        clk_a     = (op_a == OP_SET_CLK) || (op_a == OP_EN_CLK);
        clk_b     = (op_b == OP_SET_CLK) || (op_b == OP_EN_CLK);
        tmr_a     = (op_a == OP_SET_TMR) || (op_a == OP_EN_ALM) || (op_a == 3'b111);
        tmr_b     = (op_b == OP_SET_TMR) || (op_b == OP_EN_ALM) || (op_b == 3'b111);
        mode_both = (op_a == OP_MODE) && (op_b == OP_MODE);
        return (clk_a && clk_b && (a[28:25] == b[28:25])) ||
               (tmr_a && tmr_b && (a[28:24] == b[28:24])) ||
               mode_both;
    endfunction

endpackage

// File: rtl/ats21_cmd_issuer_if.sv
// ats21_cmd_issuer_if
//   Issuer <-> ATS21 timer core bus.
//   req    issuer->core  1-cycle request pulse
//   ready  core->issuer  core accepts the command halves
//   ctrlA  issuer->core  client A command half (hi then lo)
//   ctrlB  issuer->core  client B command half (hi then lo)
//   statA  core->issuer  status for A, bit0 = ack
//   statB  core->issuer  status for B, bit0 = ack
interface ats21_cmd_issuer_if;
    logic        req;
    logic        ready;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic [1:0]  statA;
    logic [1:0]  statB;

    modport master (output req, ctrlA, ctrlB, input ready, statA, statB);
    modport slave  (input req, ctrlA, ctrlB, output ready, statA, statB);
endinterface

// File: rtl/ats21_cmd_fifo.sv
// ats21_cmd_fifo
//   32-bit synchronous FIFO, DEPTH entries (power of 2, >= 2).
//   clk, reset (async, active-high), push/din write, pop advances the head,
//   dout = current head, full/empty flags registered from the entry count.
//   Push and pop in the same cycle leave the count unchanged.
module ats21_cmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] dout,
    output logic        full,
    output logic        empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW + 1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CNT_MAX);
    assign empty = (count == '0);
endmodule

// File: rtl/ats21_cmd_issuer.sv
// ats21_cmd_issuer
//   Pairs the heads of two per-client command FIFOs into one ATS21 core
//   transaction (req, ready wait, hi/lo halves, status sample) and returns a
//   per-client ack/nack/timeout response. Same-target A/B pairs are split:
//   the priority side goes first and the priority flips.
//   clk, reset           clock, async active-high reset
//   a_/b_cmd_valid/cmd/ready   client command push (NOP opcodes dropped)
//   a_/b_rsp_valid/ack/tmo     1-cycle response per issued command
//   core                 bus to the timer core (master side)
//   busy                 FSM not idle
module ats21_cmd_issuer
    import ats21_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned STAT_DELAY  = 3,
    parameter int unsigned RDY_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_cmd_valid,
    input  logic [31:0] a_cmd,
    output logic        a_cmd_ready,
    input  logic        b_cmd_valid,
    input  logic [31:0] b_cmd,
    output logic        b_cmd_ready,
    output logic        a_rsp_valid,
    output logic        a_rsp_ack,
    output logic        a_rsp_tmo,
    output logic        b_rsp_valid,
    output logic        b_rsp_ack,
    output logic        b_rsp_tmo,
    ats21_cmd_issuer_if.master core,
    output logic        busy
);
    localparam logic [7:0] TMO_LAST  = 8'(RDY_TIMEOUT - 1);
    localparam logic [7:0] STAT_LAST = 8'(STAT_DELAY - 1);

    issuer_state_e state;
    logic [7:0]    cnt;
    logic          prio_b;
    logic [31:0]   slot_a, slot_b;
    logic          slot_a_vld, slot_b_vld;
    logic [31:0]   a_head, b_head;
    logic          a_full, a_empty, b_full, b_empty;
    logic          a_push, b_push, a_pop, b_pop;
    logic          conflict, take_a, take_b, rdy_expire;
    logic          unused_stat;

    assign a_cmd_ready = !a_full;
    assign b_cmd_ready = !b_full;
    assign a_push      = a_cmd_valid && !a_full && (a_cmd[31:29] != OP_NOP);
    assign b_push      = b_cmd_valid && !b_full && (b_cmd[31:29] != OP_NOP);
    assign unused_stat = core.statA[1] ^ core.statB[1];

    ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk(clk), .reset(reset), .push(a_push), .din(a_cmd), .pop(a_pop),
        .dout(a_head), .full(a_full), .empty(a_empty)
    );

    ats21_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk(clk), .reset(reset), .push(b_push), .din(b_cmd), .pop(b_pop),
        .dout(b_head), .full(b_full), .empty(b_empty)
    );

    // Heads stay in the FIFO until the transaction is committed (LO half) or
    // abandoned on ready timeout; a losing conflict side simply stays queued.
    always_comb begin
        rdy_expire = (state == ST_WAIT_RDY) && !core.ready && (cnt == TMO_LAST);
        a_pop      = slot_a_vld && ((state == ST_ISSUE_LO) || rdy_expire);
        b_pop      = slot_b_vld && ((state == ST_ISSUE_LO) || rdy_expire);
        conflict   = !a_empty && !b_empty && targets_conflict(a_head, b_head);
        take_a     = !a_empty && !(conflict && prio_b);
        take_b     = !b_empty && !(conflict && !prio_b);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            prio_b      <= 1'b0;
            slot_a      <= '0;
            slot_b      <= '0;
            slot_a_vld  <= 1'b0;
            slot_b_vld  <= 1'b0;
            core.req    <= 1'b0;
            core.ctrlA  <= '0;
            core.ctrlB  <= '0;
            a_rsp_valid <= 1'b0;
            a_rsp_ack   <= 1'b0;
            a_rsp_tmo   <= 1'b0;
            b_rsp_valid <= 1'b0;
            b_rsp_ack   <= 1'b0;
            b_rsp_tmo   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            core.req    <= 1'b0;
            core.ctrlA  <= '0;
            core.ctrlB  <= '0;
            a_rsp_valid <= 1'b0;
            a_rsp_ack   <= 1'b0;
            a_rsp_tmo   <= 1'b0;
            b_rsp_valid <= 1'b0;
            b_rsp_ack   <= 1'b0;
            b_rsp_tmo   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!a_empty || !b_empty) begin
                        state      <= ST_REQ;
                        core.req   <= 1'b1;
                        busy       <= 1'b1;
                        slot_a     <= take_a ? a_head : '0;
                        slot_b     <= take_b ? b_head : '0;
                        slot_a_vld <= take_a;
                        slot_b_vld <= take_b;
                        if (conflict) prio_b <= !prio_b;
                    end
                end
                ST_REQ: begin
                    state <= ST_WAIT_RDY;
                    cnt   <= '0;
                end
                ST_WAIT_RDY: begin
                    if (core.ready) begin
                        state      <= ST_ISSUE_HI;
                        core.ctrlA <= slot_a[31:16];
                        core.ctrlB <= slot_b[31:16];
                    end else if (rdy_expire) begin
                        state       <= ST_RESP;
                        a_rsp_valid <= slot_a_vld;
                        a_rsp_tmo   <= slot_a_vld;
                        b_rsp_valid <= slot_b_vld;
                        b_rsp_tmo   <= slot_b_vld;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_ISSUE_HI: begin
                    state      <= ST_ISSUE_LO;
                    core.ctrlA <= slot_a[15:0];
                    core.ctrlB <= slot_b[15:0];
                end
                ST_ISSUE_LO: begin
                    state <= ST_WAIT_STAT;
                    cnt   <= '0;
                end
                ST_WAIT_STAT: begin
                    if (cnt == STAT_LAST) begin
                        state       <= ST_RESP;
                        a_rsp_valid <= slot_a_vld;
                        a_rsp_ack   <= slot_a_vld && core.statA[0];
                        b_rsp_valid <= slot_b_vld;
                        b_rsp_ack   <= slot_b_vld && core.statB[0];
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ats21_cmd_issuer.sv
module tb_ats21_cmd_issuer;
    localparam int FIFO_DEPTH  = 4;
    localparam int STAT_DELAY  = 3;
    localparam int RDY_TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_cmd_valid, b_cmd_valid;
    logic [31:0] a_cmd, b_cmd;
    logic        a_cmd_ready, b_cmd_ready;
    logic        a_rsp_valid, a_rsp_ack, a_rsp_tmo;
    logic        b_rsp_valid, b_rsp_ack, b_rsp_tmo;
    logic        busy;

    ats21_cmd_issuer_if bus();

    ats21_cmd_issuer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .STAT_DELAY(STAT_DELAY),
        .RDY_TIMEOUT(RDY_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .a_cmd_valid(a_cmd_valid), .a_cmd(a_cmd), .a_cmd_ready(a_cmd_ready),
        .b_cmd_valid(b_cmd_valid), .b_cmd(b_cmd), .b_cmd_ready(b_cmd_ready),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ack(a_rsp_ack), .a_rsp_tmo(a_rsp_tmo),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ack(b_rsp_ack), .b_rsp_tmo(b_rsp_tmo),
        .core(bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: queued commands per client and the priority side.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic        prio_b = 1'b0;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_h(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Resource class of a command: 0 none, 1 clock, 2 mode, 3 timer/alarm.
    function automatic int res_class(input logic [31:0] c);
        case (c[31:29])
            3'd1, 3'd2:       return 1;
            3'd3:             return 2;
            3'd5, 3'd6, 3'd7: return 3;
            default:          return 0;
        endcase
    endfunction

    function automatic bit tb_conflict(input logic [31:0] a, input logic [31:0] b);
        int ca, cb;
        ca = res_class(a);
        cb = res_class(b);
        if (ca == 0 || ca != cb) return 1'b0;
        if (ca == 2) return 1'b1;
        if (ca == 1) return a[28:25] == b[28:25];
        return a[28:24] == b[28:24];
    endfunction

    // One push cycle on both ports; returns the cycle number of the push.
    task automatic push(input logic av, input logic [31:0] a,
                        input logic bv, input logic [31:0] b, output int c0);
        a_cmd_valid = av; a_cmd = a;
        b_cmd_valid = bv; b_cmd = b;
        chk_b("a_cmd_ready", a_cmd_ready, qa.size() < FIFO_DEPTH);
        chk_b("b_cmd_ready", b_cmd_ready, qb.size() < FIFO_DEPTH);
        if (av && qa.size() < FIFO_DEPTH && a[31:29] != 3'd0) qa.push_back(a);
        if (bv && qb.size() < FIFO_DEPTH && b[31:29] != 3'd0) qb.push_back(b);
        c0 = cyc;
        step();
        a_cmd_valid = 1'b0;
        b_cmd_valid = 1'b0;
    endtask

    // Follows one transaction from req to response. rdy_delay < 0: ready never.
    task automatic run_txn(input int rdy_delay, output int rsp_cyc);
        logic        va, vb, tmo, sta, stb;
        logic [31:0] sa, sb;
        int          k;
        va = qa.size() != 0;
        vb = qb.size() != 0;
        if (va && vb && tb_conflict(qa[0], qb[0])) begin
            if (prio_b) va = 1'b0; else vb = 1'b0;
            prio_b = ~prio_b;
        end
        sa = va ? qa[0] : 32'h0;
        sb = vb ? qb[0] : 32'h0;
        k = 0;
        while (bus.req !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        chk_b("req_seen", bus.req, 1'b1);
        chk_b("busy_run", busy, 1'b1);
        step();
        chk_b("req_pulse", bus.req, 1'b0);
        tmo = 1'b0;
        for (int w = 0; w < RDY_TIMEOUT; w++) begin
            bus.ready = (rdy_delay >= 0) && (w >= rdy_delay);
            chk_h("ctrlA_wait", bus.ctrlA, 16'h0);
            step();
            if (bus.ready) break;
            if (w == RDY_TIMEOUT - 1) tmo = 1'b1;
        end
        bus.ready = 1'b0;
        if (!tmo) begin
            chk_h("ctrlA_hi", bus.ctrlA, sa[31:16]);
            chk_h("ctrlB_hi", bus.ctrlB, sb[31:16]);
            step();
            chk_h("ctrlA_lo", bus.ctrlA, sa[15:0]);
            chk_h("ctrlB_lo", bus.ctrlB, sb[15:0]);
            for (int s = 0; s <= STAT_DELAY; s++) begin
                bus.statA = 2'($urandom);
                bus.statB = 2'($urandom);
                step();
                if (s < STAT_DELAY) begin
                    chk_b("a_rsp_early", a_rsp_valid, 1'b0);
                    chk_b("b_rsp_early", b_rsp_valid, 1'b0);
                    chk_h("ctrlA_stat", bus.ctrlA, 16'h0);
                end
            end
            // The status sampled is the one present at the edge into RESP.
            sta = bus.statA[0];
            stb = bus.statB[0];
            chk_b("a_rsp_valid", a_rsp_valid, va);
            chk_b("a_rsp_ack", a_rsp_ack, va & sta);
            chk_b("a_rsp_tmo", a_rsp_tmo, 1'b0);
            chk_b("b_rsp_valid", b_rsp_valid, vb);
            chk_b("b_rsp_ack", b_rsp_ack, vb & stb);
            chk_b("b_rsp_tmo", b_rsp_tmo, 1'b0);
        end else begin
            chk_b("a_tmo_valid", a_rsp_valid, va);
            chk_b("a_tmo_flag", a_rsp_tmo, va);
            chk_b("a_tmo_ack", a_rsp_ack, 1'b0);
            chk_b("b_tmo_valid", b_rsp_valid, vb);
            chk_b("b_tmo_flag", b_rsp_tmo, vb);
            chk_b("b_tmo_ack", b_rsp_ack, 1'b0);
        end
        if (va) void'(qa.pop_front());
        if (vb) void'(qb.pop_front());
        rsp_cyc = cyc;
        step();
        chk_b("busy_end", busy, 1'b0);
        chk_b("a_rsp_pulse", a_rsp_valid, 1'b0);
        chk_b("b_rsp_pulse", b_rsp_valid, 1'b0);
    endtask

    task automatic drain();
        int rc, d;
        while (qa.size() != 0 || qb.size() != 0) begin
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 4));
            run_txn(d, rc);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0, rc, k;
        logic        av, bv;
        logic [31:0] ca, cb;

        reset = 1'b1;
        a_cmd_valid = 1'b0; b_cmd_valid = 1'b0;
        a_cmd = '0; b_cmd = '0;
        bus.ready = 1'b0; bus.statA = '0; bus.statB = '0;
        #12;
        chk_b("rst_req", bus.req, 1'b0);
        chk_h("rst_ctrlA", bus.ctrlA, 16'h0);
        chk_h("rst_ctrlB", bus.ctrlB, 16'h0);
        chk_b("rst_a_rsp", a_rsp_valid, 1'b0);
        chk_b("rst_b_rsp", b_rsp_valid, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_a_rdy", a_cmd_ready, 1'b1);
        chk_b("rst_b_rdy", b_cmd_ready, 1'b1);
        reset = 1'b0;
        step();

        // Single A command, ready on the second wait cycle.
        push(1'b1, 32'h2A00_0005, 1'b0, 32'h0, c0);
        run_txn(1, rc);

        // Non-conflicting pair in one transaction; minimum latency.
        push(1'b1, 32'h2200_0010, 1'b1, 32'h2400_0020, c0);
        run_txn(0, rc);
        chk_i("latency", rc - c0, 6 + STAT_DELAY);

        // Alarm-target conflict: A first, then B; next conflict goes B first.
        push(1'b1, 32'hA100_0100, 1'b1, 32'hC100_0200, c0);
        drain();
        push(1'b1, 32'hA100_0300, 1'b1, 32'hE100_0400, c0);
        drain();
        push(1'b1, 32'h6000_0001, 1'b1, 32'h7F00_0002, c0);
        drain();
        push(1'b1, 32'h8000_0001, 1'b1, 32'h8000_0002, c0);
        drain();

        // Ready timeout on a pair.
        push(1'b1, 32'h3123_4567, 1'b1, 32'h5F00_0001, c0);
        run_txn(-1, rc);

        // NOP commands are accepted but never start a transaction.
        push(1'b1, 32'h1FFF_FFFF, 1'b1, 32'h0000_0001, c0);
        step();
        chk_b("nop_idle", busy, 1'b0);
        chk_b("nop_no_req", bus.req, 1'b0);

        // Fill A's FIFO while the core never becomes ready.
        for (int i = 0; i <= FIFO_DEPTH; i++)
            push(1'b1, 32'h2000_0000 | 32'(i + 1), 1'b0, 32'h0, c0);
        k = 0;
        while (a_rsp_valid !== 1'b1 && k < 3 * RDY_TIMEOUT) begin
            step();
            k++;
        end
        chk_b("fill_tmo_seen", a_rsp_valid, 1'b1);
        chk_b("fill_tmo_flag", a_rsp_tmo, 1'b1);
        chk_b("fill_tmo_ack", a_rsp_ack, 1'b0);
        void'(qa.pop_front());
        chk_b("fill_rdy_after", a_cmd_ready, 1'b1);
        step();
        chk_b("fill_busy", busy, 1'b0);
        drain();

        // Randomized pairs from a narrow target space to provoke conflicts.
        for (int it = 0; it < 40; it++) begin
            av = 1'($urandom);
            bv = 1'($urandom);
            ca = {3'($urandom), 5'($urandom_range(0, 2)), 24'($urandom)};
            cb = {3'($urandom), 5'($urandom_range(0, 2)), 24'($urandom)};
            push(av, ca, bv, cb, c0);
            drain();
            step();
        end

        // Asynchronous reset while the HI half is on the bus.
        push(1'b1, 32'h2A00_1234, 1'b1, 32'hA000_5678, c0);
        k = 0;
        while (bus.req !== 1'b1 && k < 8) begin
            step();
            k++;
        end
        step();
        bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        chk_h("pre_rst_hi", bus.ctrlA, 16'h2A00);
        #2;
        reset = 1'b1;
        #1;
        chk_b("arst_req", bus.req, 1'b0);
        chk_h("arst_ctrlA", bus.ctrlA, 16'h0);
        chk_h("arst_ctrlB", bus.ctrlB, 16'h0);
        chk_b("arst_busy", busy, 1'b0);
        chk_b("arst_a_rsp", a_rsp_valid, 1'b0);
        chk_b("arst_a_rdy", a_cmd_ready, 1'b1);
        qa.delete();
        qb.delete();
        prio_b = 1'b0;
        #3;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_b("post_rst_idle", busy, 1'b0);
            chk_b("post_rst_rsp", a_rsp_valid | b_rsp_valid, 1'b0);
        end

        // Priority returned to A after reset.
        push(1'b1, 32'h6000_0011, 1'b1, 32'h6000_0022, c0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
